// File: rtl/segasys1_hiscore_ctl_if.sv
`default_nettype none
// ============================================================================
//  Module   : segasys1_hiscore_ctl_if
//  Brief    : Core-side and host-side signal bundle of the high-score controller.
//  Revision : 1.0 - initial release
// ============================================================================
interface segasys1_hiscore_ctl_if;
    logic        VBLK;
    logic [15:0] HSAD;
    logic [7:0]  HSDI;
    logic [7:0]  HSDO;
    logic        HSWE;
    logic        PAUSE_N;
    logic [7:0]  HOST_AD;
    logic [7:0]  HOST_DI;
    logic        HOST_WE;
    logic [7:0]  HOST_DO;
    logic        HOST_LOADED;
    logic        DUMP_REQ;
    logic        BUSY;
    logic        DONE;
    logic        ERR;

    modport master (
        input  VBLK, HSDO, HOST_AD, HOST_DI, HOST_WE, HOST_LOADED, DUMP_REQ,
        output HSAD, HSDI, HSWE, PAUSE_N, HOST_DO, BUSY, DONE, ERR
    );

    modport slave (
        output VBLK, HSDO, HOST_AD, HOST_DI, HOST_WE, HOST_LOADED, DUMP_REQ,
        input  HSAD, HSDI, HSWE, PAUSE_N, HOST_DO, BUSY, DONE, ERR
    );
endinterface
`default_nettype wire

// File: rtl/segasys1_hiscore_ctl.sv
`default_nettype none
// ============================================================================
//  Module   : segasys1_hiscore_ctl
//  Brief    : Pauses the core, checks signatures, restores/dumps the high-score
//             table between core work RAM and a host-visible buffer.
//             Optional read-back verify when HISCORE_VERIFY_EN is defined.
//  Revision : 1.0 - initial release
// ============================================================================
module segasys1_hiscore_ctl #(
    parameter logic [15:0] TBL_ADDR  = 16'hC000,
    parameter int          TBL_LEN   = 64,
    parameter logic [7:0]  SIG_START = 8'h00,
    parameter logic [7:0]  SIG_END   = 8'h00,
    parameter int          RD_LAT    = 2,
    parameter int          BOOT_VBL  = 60
) (
    input  wire logic              clk48M,
    input  wire logic              reset_n,
    segasys1_hiscore_ctl_if.master hs
);
    localparam logic [15:0] c_END_ADDR = TBL_ADDR + 16'(TBL_LEN - 1);
    localparam logic [7:0]  c_LAST_IDX = 8'(TBL_LEN - 1);
    localparam logic [1:0]  c_RD_LAT   = 2'(RD_LAT);
    localparam int          c_VW       = (BOOT_VBL < 2) ? 1 : $clog2(BOOT_VBL);
    localparam logic [c_VW-1:0] c_VBL_LAST = c_VW'(BOOT_VBL - 1);

    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_WAIT_BOOT = 4'd1,
        S_PAUSE     = 4'd2,
        S_CHK_S     = 4'd3,
        S_CHK_E     = 4'd4,
        S_RESTORE   = 4'd5,
        S_ARMED     = 4'd6,
        S_DUMP      = 4'd7
`ifdef HISCORE_VERIFY_EN
        , S_VERIFY  = 4'd8
`endif
    } state_t;

    state_t          r_state;
    logic            r_vblk;
    logic            r_dreq;
    logic            r_dump_pend;
    logic            r_op_dump;
    logic            r_retry;
    logic [c_VW-1:0] r_vbl_cnt;
    logic [1:0]      r_lat;
    logic            r_ph;
    logic [7:0]      r_idx;
    logic [15:0]     r_hsad;
    logic [7:0]      r_hsdi;
    logic            r_hswe;
    logic            r_pause_n;
    logic            r_done;
    logic [7:0]      r_host_do;
    logic [7:0]      r_buf [0:255];

    logic            w_vblk_rise;
    logic            w_dreq_rise;
    logic            w_sample;
    logic            w_int_we;
    logic [7:0]      w_int_rd;

    assign w_vblk_rise = hs.VBLK & ~r_vblk;
    assign w_dreq_rise = hs.DUMP_REQ & ~r_dreq;
    assign w_sample    = (r_lat == c_RD_LAT);
    assign w_int_we    = reset_n && (r_state == S_DUMP) && w_sample;
    assign w_int_rd    = r_buf[r_idx];

    // Buffer is never reset so an image survives a core reset; a dump write wins a same-address clash.
    always_ff @(posedge clk48M) begin
        if (w_int_we) begin
            r_buf[r_idx] <= hs.HSDO;
        end
        if (hs.HOST_WE && !(w_int_we && (hs.HOST_AD == r_idx))) begin
            r_buf[hs.HOST_AD] <= hs.HOST_DI;
        end
        r_host_do <= r_buf[hs.HOST_AD];
    end

`ifdef HISCORE_VERIFY_EN
    logic r_err;
`endif

    always_ff @(posedge clk48M) begin
        if (!reset_n) begin
            r_state     <= S_IDLE;
            r_vblk      <= 1'b0;
            r_dreq      <= 1'b0;
            r_dump_pend <= 1'b0;
            r_op_dump   <= 1'b0;
            r_retry     <= 1'b0;
            r_vbl_cnt   <= '0;
            r_lat       <= 2'd0;
            r_ph        <= 1'b0;
            r_idx       <= 8'd0;
            r_hsad      <= TBL_ADDR;
            r_hsdi      <= 8'd0;
            r_hswe      <= 1'b0;
            r_pause_n   <= 1'b1;
            r_done      <= 1'b0;
`ifdef HISCORE_VERIFY_EN
            r_err       <= 1'b0;
`endif
        end else begin
            r_vblk <= hs.VBLK;
            r_dreq <= hs.DUMP_REQ;
            r_done <= 1'b0;
            r_hswe <= 1'b0;
            if (w_dreq_rise) begin
                r_dump_pend <= 1'b1;
            end
            case (r_state)
                S_IDLE: r_state <= S_WAIT_BOOT;
                S_WAIT_BOOT: begin
                    // After a failed signature check only a single VBLK edge is awaited.
                    if (w_vblk_rise) begin
                        if (r_retry || (r_vbl_cnt == c_VBL_LAST)) begin
                            r_retry <= 1'b0;
                            if (hs.HOST_LOADED) begin
                                r_state   <= S_PAUSE;
                                r_op_dump <= 1'b0;
                                r_pause_n <= 1'b0;
                                r_lat     <= 2'd0;
                            end else begin
                                r_state <= S_ARMED;
                            end
                        end else begin
                            r_vbl_cnt <= r_vbl_cnt + c_VW'(1);
                        end
                    end
                end
                S_PAUSE: begin
                    if (!r_op_dump && !hs.HOST_LOADED) begin
                        r_pause_n <= 1'b1;
                        r_state   <= S_ARMED;
                    end else if (r_lat == 2'd1) begin
                        r_lat   <= 2'd0;
                        r_idx   <= 8'd0;
                        r_hsad  <= TBL_ADDR;
                        r_state <= r_op_dump ? S_DUMP : S_CHK_S;
                    end else begin
                        r_lat <= r_lat + 2'd1;
                    end
                end
                S_CHK_S, S_CHK_E: begin
                    if (!hs.HOST_LOADED) begin
                        r_pause_n <= 1'b1;
                        r_state   <= S_ARMED;
                    end else if (w_sample) begin
                        r_lat <= 2'd0;
                        if ((r_state == S_CHK_S) && (hs.HSDO == SIG_START)) begin
                            r_hsad  <= c_END_ADDR;
                            r_state <= S_CHK_E;
                        end else if ((r_state == S_CHK_E) && (hs.HSDO == SIG_END)) begin
                            r_idx   <= 8'd0;
                            r_ph    <= 1'b0;
                            r_state <= S_RESTORE;
                        end else begin
                            r_pause_n <= 1'b1;
                            r_retry   <= 1'b1;
                            r_state   <= S_WAIT_BOOT;
                        end
                    end else begin
                        r_lat <= r_lat + 2'd1;
                    end
                end
                S_RESTORE: begin
                    if (!r_ph) begin
                        r_hsad <= TBL_ADDR + {8'h00, r_idx};
                        r_hsdi <= w_int_rd;
                        r_hswe <= 1'b1;
                        r_ph   <= 1'b1;
                    end else begin
                        r_ph <= 1'b0;
                        if (r_idx == c_LAST_IDX) begin
`ifdef HISCORE_VERIFY_EN
                            r_idx   <= 8'd0;
                            r_lat   <= 2'd0;
                            r_hsad  <= TBL_ADDR;
                            r_state <= S_VERIFY;
`else
                            r_done    <= 1'b1;
                            r_pause_n <= 1'b1;
                            r_state   <= S_ARMED;
`endif
                        end else begin
                            r_idx <= r_idx + 8'd1;
                        end
                    end
                end
`ifdef HISCORE_VERIFY_EN
                S_VERIFY,
`endif
                S_DUMP: begin
                    if (w_sample) begin
                        r_lat <= 2'd0;
`ifdef HISCORE_VERIFY_EN
                        if ((r_state == S_VERIFY) && (hs.HSDO != w_int_rd)) begin
                            r_err <= 1'b1;
                        end
`endif
                        if (r_idx == c_LAST_IDX) begin
                            r_done    <= 1'b1;
                            r_pause_n <= 1'b1;
                            r_state   <= S_ARMED;
                        end else begin
                            r_idx  <= r_idx + 8'd1;
                            r_hsad <= r_hsad + 16'd1;
                        end
                    end else begin
                        r_lat <= r_lat + 2'd1;
                    end
                end
                S_ARMED: begin
                    if (r_dump_pend || w_dreq_rise) begin
                        r_dump_pend <= 1'b0;
                        r_op_dump   <= 1'b1;
                        r_pause_n   <= 1'b0;
                        r_lat       <= 2'd0;
                        r_state     <= S_PAUSE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign hs.HSAD    = r_hsad;
    assign hs.HSDI    = r_hsdi;
    assign hs.HSWE    = r_hswe;
    assign hs.PAUSE_N = r_pause_n;
    assign hs.HOST_DO = r_host_do;
    assign hs.DONE    = r_done;
    assign hs.BUSY    = !((r_state == S_IDLE) || (r_state == S_WAIT_BOOT) || (r_state == S_ARMED));
`ifdef HISCORE_VERIFY_EN
    assign hs.ERR     = r_err;
`else
    assign hs.ERR     = 1'b0;
`endif
endmodule
`default_nettype wire

// File: tb/tb_segasys1_hiscore_ctl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_segasys1_hiscore_ctl
//  Brief    : Scoreboard bench: expected core writes, DONE latencies and host
//             read-back values are queued by stimulus and checked by a monitor.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_segasys1_hiscore_ctl;
    localparam logic [15:0] A0    = 16'hC000;
    localparam int          L     = 4;
    localparam int          RL    = 2;
    localparam logic [7:0]  SIG_S = 8'h5A;
    localparam logic [7:0]  SIG_E = 8'hC3;
`ifdef HISCORE_VERIFY_EN
    localparam int D_VER = (RL + 1) * L;
`else
    localparam int D_VER = 0;
`endif
    // Cycles from PAUSE entry through the DONE cycle inclusive; boot adds two signature reads.
    localparam int D_DUMP    = 2 + (RL + 1) * L + 1;
    localparam int D_RESTORE = 2 + 2 * (RL + 1) + 2 * L + 1 + D_VER;

    logic clk48M = 1'b0;
    logic reset_n;
    always #5 clk48M = ~clk48M;

    segasys1_hiscore_ctl_if hs();

    segasys1_hiscore_ctl #(
        .TBL_ADDR (A0),
        .TBL_LEN  (L),
        .SIG_START(SIG_S),
        .SIG_END  (SIG_E),
        .RD_LAT   (RL),
        .BOOT_VBL (2)
    ) dut (
        .clk48M (clk48M),
        .reset_n(reset_n),
        .hs     (hs)
    );

    // Core model: work RAM with RD_LAT read latency and an optional fault injector.
    logic [7:0]  mem [0:65535];
    logic [15:0] ap0, ap1;
    int          fail_left = 0;
    bit          corrupt   = 1'b0;
    always @(posedge clk48M) begin
        ap0 <= hs.HSAD;
        ap1 <= ap0;
        if (hs.HSWE)
            mem[hs.HSAD] <= (corrupt && hs.HSAD == A0 + 16'd2) ? ~hs.HSDI : hs.HSDI;
    end
    assign hs.HSDO = (ap1 == A0 + 16'(L - 1) && fail_left > 0) ? 8'h55 : mem[ap1];

    typedef struct { int due; logic [7:0] exp; } rd_t;
    logic [23:0] exp_wr[$];
    int          exp_done[$];
    rd_t         rd_q[$];

    int n_pass = 0, n_total = 0;
    int cyc = 0, fall_cyc = 0, fall_scn = 0, hswe_scn = 0, rel_cnt = 0, done_cnt = 0;
    bit prev_pn = 1'b1;
    logic [7:0] img [0:3];

    task automatic chk(input string nm, input longint act, input longint exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    endtask

    always @(posedge clk48M) begin
        rd_t r;
        #1;
        cyc++;
        if (prev_pn && !hs.PAUSE_N) begin
            fall_cyc = cyc;
            fall_scn++;
        end
        if (!prev_pn && hs.PAUSE_N && reset_n && !hs.DONE) begin
            rel_cnt++;
            chk("no_hswe_before_release", hswe_scn, 0);
            if (fail_left > 0) fail_left--;
        end
        if (hs.DONE) begin
            done_cnt++;
            chk("pause_n_high_at_done", hs.PAUSE_N, 1);
            chk("done_expected", int'(exp_done.size() > 0), 1);
            if (exp_done.size() > 0) chk("done_latency", cyc - fall_cyc + 1, exp_done.pop_front());
        end
        if (hs.HSWE) begin
            hswe_scn++;
            chk("hswe_while_paused", hs.PAUSE_N, 0);
            chk("hswe_expected", int'(exp_wr.size() > 0), 1);
            if (exp_wr.size() > 0) chk("hswe_addr_data", {hs.HSAD, hs.HSDI}, exp_wr.pop_front());
        end
        if (rd_q.size() > 0 && rd_q[0].due == cyc) begin
            r = rd_q.pop_front();
            chk("host_do", hs.HOST_DO, r.exp);
        end
        prev_pn = hs.PAUSE_N;
    end

    task automatic step();
        @(posedge clk48M);
        #2;
    endtask

    task automatic vblank();
        hs.VBLK = 1'b1;
        repeat (3) step();
        hs.VBLK = 1'b0;
        repeat (6) step();
    endtask

    task automatic host_write(input logic [7:0] ad, input logic [7:0] d);
        hs.HOST_AD = ad;
        hs.HOST_DI = d;
        hs.HOST_WE = 1'b1;
        step();
        hs.HOST_WE = 1'b0;
    endtask

    task automatic host_read(input logic [7:0] ad, input logic [7:0] e);
        hs.HOST_AD = ad;
        rd_q.push_back('{cyc + 1, e});
        step();
    endtask

    task automatic dump_pulse();
        hs.DUMP_REQ = 1'b1;
        repeat (2) step();
        hs.DUMP_REQ = 1'b0;
        step();
    endtask

    task automatic wait_done(input string nm, input int target, input int limit);
        for (int i = 0; i < limit && done_cnt < target; i++) step();
        chk(nm, int'(done_cnt >= target), 1);
    endtask

    // Starts a boot scenario: reset, load image, plant signatures, queue the expected restore.
    task automatic boot_setup(input int n_wr, input bit want_done);
        reset_n = 1'b0;
        repeat (2) step();
        hswe_scn = 0; fall_scn = 0; rel_cnt = 0;
        reset_n = 1'b1;
        mem[A0] = SIG_S;
        mem[A0 + 16'(L - 1)] = SIG_E;
        for (int i = 0; i < L; i++) host_write(8'(i), img[i]);
        for (int i = 0; i < n_wr; i++) exp_wr.push_back({A0 + 16'(i), img[i]});
        if (want_done) exp_done.push_back(D_RESTORE);
        hs.HOST_LOADED = 1'b1;
    endtask

    initial begin
        int t;
        reset_n = 1'b0;
        hs.VBLK = 1'b0; hs.HOST_AD = 8'd0; hs.HOST_DI = 8'd0; hs.HOST_WE = 1'b0;
        hs.HOST_LOADED = 1'b0; hs.DUMP_REQ = 1'b0;
        repeat (3) step();
        chk("rst_pause_n", hs.PAUSE_N, 1);
        chk("rst_hswe", hs.HSWE, 0);
        chk("rst_hsad", hs.HSAD, A0);
        chk("rst_hsdi", hs.HSDI, 0);
        chk("rst_done", hs.DONE, 0);
        chk("rst_err", hs.ERR, 0);
        chk("rst_busy", hs.BUSY, 0);

        // Boot with a loaded image.
        img[0] = 8'hAA; img[1] = 8'hBB; img[2] = 8'hCC; img[3] = 8'hDD;
        boot_setup(L, 1'b1);
        t = done_cnt + 1;
        vblank();
        repeat (30) step();
        chk("no_pause_before_boot_vbl", fall_scn, 0);
        vblank();
        wait_done("restore_done_timeout", t, 100);
        chk("restore_hswe_count", hswe_scn, L);
        chk("idle_after_restore", hs.BUSY, 0);
        chk("err_after_clean_restore", hs.ERR, 0);
        for (int i = 0; i < L; i++) chk("core_ram_restored", mem[A0 + 16'(i)], img[i]);

        // Signature mismatch three times, then success.
        for (int i = 0; i < L; i++) img[i] = 8'($urandom);
        boot_setup(L, 1'b1);
        fail_left = 3;
        t = done_cnt + 1;
        vblank();
        vblank();
        for (int i = 0; i < 8 && done_cnt < t; i++) vblank();
        wait_done("retry_done_timeout", t, 100);
        chk("sig_releases", rel_cnt, 3);
        chk("retry_hswe_count", hswe_scn, L);

        // Dump with known then random core contents; second request arrives while busy.
        for (int i = 0; i < L; i++) mem[A0 + 16'(i)] = 8'(i + 1);
        exp_done.push_back(D_DUMP);
        t = done_cnt + 1;
        dump_pulse();
        wait_done("dump_done_timeout", t, 100);
        for (int i = 0; i < L; i++) host_read(8'(i), 8'(i + 1));
        for (int i = 0; i < L; i++) mem[A0 + 16'(i)] = 8'($urandom);
        exp_done.push_back(D_DUMP);
        exp_done.push_back(D_DUMP);
        t = done_cnt + 2;
        dump_pulse();
        repeat (3) step();
        chk("busy_during_dump", hs.BUSY, 1);
        dump_pulse();
        wait_done("dump2_done_timeout", t, 200);
        for (int i = L - 1; i >= 0; i--) host_read(8'(i), mem[A0 + 16'(i)]);
        step();

        // No image loaded: boot straight to ARMED, then a dump proves it is armed.
        reset_n = 1'b0;
        repeat (2) step();
        hswe_scn = 0; fall_scn = 0;
        hs.HOST_LOADED = 1'b0;
        reset_n = 1'b1;
        repeat (3) vblank();
        chk("noload_no_pause", fall_scn, 0);
        chk("noload_no_hswe", hswe_scn, 0);
        chk("noload_not_busy", hs.BUSY, 0);
        exp_done.push_back(D_DUMP);
        t = done_cnt + 1;
        dump_pulse();
        wait_done("noload_dump_timeout", t, 100);

        // Reset after the second restore write.
        img[0] = 8'hAA; img[1] = 8'hBB; img[2] = 8'hCC; img[3] = 8'hDD;
        boot_setup(2, 1'b0);
        vblank();
        hs.VBLK = 1'b1;
        for (int i = 0; i < 100 && hswe_scn < 2; i++) begin
            if (i == 3) hs.VBLK = 1'b0;
            step();
        end
        hs.VBLK = 1'b0;
        chk("second_hswe_seen", hswe_scn, 2);
        reset_n = 1'b0;
        step();
        chk("midrst_pause_n", hs.PAUSE_N, 1);
        chk("midrst_hswe", hs.HSWE, 0);
        chk("midrst_done", hs.DONE, 0);
        hs.HOST_LOADED = 1'b0;
        step();
        reset_n = 1'b1;
        for (int i = 0; i < L; i++) host_read(8'(i), img[i]);
        step();

`ifdef HISCORE_VERIFY_EN
        for (int i = 0; i < L; i++) img[i] = 8'($urandom);
        boot_setup(L, 1'b1);
        corrupt = 1'b1;
        t = done_cnt + 1;
        repeat (2) vblank();
        wait_done("verify_done_timeout", t, 100);
        chk("verify_err_set", hs.ERR, 1);
        repeat (10) step();
        chk("verify_err_sticky", hs.ERR, 1);
        corrupt = 1'b0;
`endif

        repeat (4) step();
        chk("writes_drained", exp_wr.size(), 0);
        chk("dones_drained", exp_done.size(), 0);
        chk("reads_drained", rd_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end
endmodule
`default_nettype wire
